trigger_generator_mc: RTL and testbench
=======================================

Name: trigger_generator_mc

Overview:
- Parametrised successor to the DTB trigger source. Produces a TRG_W-bit trigger token on the sync (clock-enable) grid.
- Four selectable modes: off, periodic, pseudo-random, periodic-burst.
- Adds programmable holdoff (dead time), a trigger count limit with a done flag, a start/stop state machine, and a running trigger counter.
- Sits between the sequencer control registers and the trigger token mux.

Parameters:
- CNT_W, 32, width of rate/period counter and random comparator (8..32).
- TRG_W, 5, trigger token width.
- TRG_BIT, 1, bit position in trg driven by a generated trigger.
- HOLD_W, 16, width of holdoff and burst_len.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sync  in  1  clock enable; all state advances only on clk edges with sync=1
- enable  in  1  run request; level, sampled on sync
- mode  in  2  0=off, 1=periodic, 2=random, 3=burst; sampled at start only
- rate  in  CNT_W  period-1 (modes 1/3) or random threshold (mode 2)
- holdoff  in  HOLD_W  sync ticks suppressed after each trigger
- burst_len  in  HOLD_W  triggers per burst (0 treated as 1)
- count_limit  in  32  stop after this many triggers; 0 = unlimited
- trg  out  TRG_W  trigger token; only bit TRG_BIT ever set
- busy  out  1  state RUN
- done  out  1  state DONE
- trg_count  out  32  triggers issued since last start

Behaviour:
- Reset: trg=0, busy=0, done=0, trg_count=0, state IDLE, period cnt=0, hold cnt=0, burst cnt=0, LFSRs sa=sb=sc=32'hFFFFFFFF.
- Outputs are registered and change only on sync ticks. trg is held between ticks, so a trigger is high for exactly one sync period.
- FSM, evaluated on each sync tick:
  - IDLE: enable=1 and mode!=0 -> RUN. Latch mode; cnt<=rate; hold<=0; burst<=0; trg_count<=0.
  - RUN: enable=0 -> IDLE (abort). trg_count reaching count_limit (nonzero) on an issued trigger -> DONE.
  - DONE: trg=0; enable=0 -> IDLE. enable held high never restarts.
  - Abort or reset mid-burst discards the burst. trg returns to 0 on the next sync tick; trg_count is retained until the next start.
- Period counter (modes 1/3, RUN):
  - cnt==0 -> expiry, cnt<=rate; else cnt<=cnt-1.
  - First expiry occurs rate+1 ticks after the start tick; period is rate+1 ticks. rate=0 gives an expiry every tick.
- Random (mode 2): the LFSRs advance every sync tick in all states (free-running).
  - Per-tick update: sa<={sa[19:1], sa[18:6]^sa[31:19]}; sb<={sb[27:3], sb[29:23]^sb[31:25]}; sc<={sc[14:4], sc[28:8]^sc[31:11]}.
  - s=sa^sb^sc. Candidate when s[31:32-CNT_W] < rate (unsigned), evaluated on pre-update s.
  - rate=0 never fires.
- Burst (mode 3):
  - Expiry with burst==0 loads burst<=max(burst_len,1). Each tick with burst>0 gives a candidate and burst<=burst-1.
  - Expiries during an active burst are ignored.
- Candidate source by mode: mode 1 = expiry; mode 2 = random compare; mode 3 = burst>0.
- Holdoff: a candidate with hold==0 issues a trigger (trg[TRG_BIT]<=1, trg_count+1, hold<=holdoff). A candidate with hold>0 is dropped and does not count.
  - hold decrements each tick while >0. Counters keep running during holdoff.
  - holdoff=0 means no dead time.
- Trigger latency: trg asserts on the same sync tick the candidate is evaluated.
- Limit boundary: the trigger that makes trg_count==count_limit is issued; DONE is entered on that same tick.
- trg_count saturates at 32'hFFFFFFFF.

Optional Feature:
- Macro TRG_EXT_EN.
- When defined: extra port ext_trg (in, 1).
  - Synchronised through 2 flops on clk, then rising-edge detected on sync ticks.
  - In RUN, an edge is an additional candidate, OR'd with the mode candidate and subject to holdoff and count_limit. Edges are ignored in IDLE/DONE.
  - Simultaneous edge and internal candidate produce one trigger, one count.
- When undefined: no port, no synchroniser, behaviour identical with ext_trg=0.

Test Plan:
- Mode 1, rate=3, holdoff=0, count_limit=0, sync every clk, enable at tick 0 -> trg[1] high at ticks 4, 8, 12, ...; busy=1; trg_count increments by 1 per trigger.
- Mode 1, rate=0, holdoff=2 -> triggers at ticks 1, 4, 7, ... (every 3 ticks); 2 of every 3 candidates dropped; trg_count counts issued triggers only.
- Mode 3, rate=9, burst_len=3, count_limit=5 -> bursts of 3 triggers on consecutive ticks starting at ticks 10 and 20; after 5 triggers done=1, busy=0, trg=0; enable kept high stays in DONE; enable low -> IDLE.
- Mode 2, rate=0 for 1000 ticks -> zero triggers. rate=2^CNT_W-1 -> trigger on nearly every tick. Trigger pattern after reset bit-exactly matches the software LFSR model.
- Mode 1, rate=7, enable dropped at tick 5 -> IDLE, no trigger. Asynchronous reset pulse mid-RUN -> all outputs 0 immediately.
- With TRG_EXT_EN: ext_trg pulse in RUN during mode-1 gap -> one trigger 3 clk later (sync every clk). ext_trg pulse during holdoff -> dropped.

Source files
------------

// File: rtl/trigger_generator_mc.sv
// Trigger source: off/periodic/random/burst modes with holdoff, count limit, start/stop FSM.
// Define TRG_EXT_EN to add the synchronised external trigger input ext_trg.
module trigger_generator_mc #(
    parameter int CNT_W   = 32,
    parameter int TRG_W   = 5,
    parameter int TRG_BIT = 1,
    parameter int HOLD_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  rate,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic [HOLD_W-1:0] burst_len,
    input  logic [31:0]       count_limit,
`ifdef TRG_EXT_EN
    input  logic              ext_trg,
`endif
    output logic [TRG_W-1:0]  trg,
    output logic              busy,
    output logic              done,
    output logic [31:0]       trg_count
);

    localparam logic [1:0] MODE_PER = 2'd1;
    localparam logic [1:0] MODE_RND = 2'd2;
    localparam logic [1:0] MODE_BST = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        mode_q, mode_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [HOLD_W-1:0] hold, hold_nxt;
    logic [HOLD_W-1:0] burst, burst_nxt;
    logic [31:0]       count_nxt;
    logic              trg_q, trg_nxt;

    logic [31:0] sa, sb, sc, s;

    logic              expiry;
    logic [HOLD_W-1:0] burst_ld;
    logic [HOLD_W-1:0] burst_eff;
    logic              rnd_hit;
    logic              mode_cand;
    logic              cand;
    logic              issue;
    logic              ext_edge;

`ifdef TRG_EXT_EN
    logic ext_s1, ext_s2, ext_prev;

    // Two-flop synchroniser runs on every clk; edge detect steps on sync ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_s1   <= 1'b0;
            ext_s2   <= 1'b0;
            ext_prev <= 1'b0;
        end else begin
            ext_s1 <= ext_trg;
            ext_s2 <= ext_s1;
            if (sync) begin
                ext_prev <= ext_s2;
            end
        end
    end

    assign ext_edge = ext_s2 & ~ext_prev;
`else
    assign ext_edge = 1'b0;
`endif

    // Free-running generators: they advance in every state, not only RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa <= '1;
            sb <= '1;
            sc <= '1;
        end else if (sync) begin
            sa <= {sa[19:1], sa[18:6] ^ sa[31:19]};
            sb <= {sb[27:3], sb[29:23] ^ sb[31:25]};
            sc <= {sc[14:4], sc[28:8] ^ sc[31:11]};
        end
    end

    assign s = sa ^ sb ^ sc;

    assign expiry   = (cnt == '0);
    assign burst_ld = (burst_len == '0) ? HOLD_ONE : burst_len;
    assign rnd_hit  = (s[31 -: CNT_W] < rate);

    // An expiry that finds no burst in progress starts one on the same tick.
    assign burst_eff = (expiry && burst == '0) ? burst_ld : burst;

    always_comb begin
        mode_cand = 1'b0;
        case (mode_q)
            MODE_PER: mode_cand = expiry;
            MODE_RND: mode_cand = rnd_hit;
            MODE_BST: mode_cand = (burst_eff != '0);
            default:  mode_cand = 1'b0;
        endcase
    end

    assign cand  = mode_cand | ext_edge;
    assign issue = cand && (hold == '0);

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_q;
        cnt_nxt   = cnt;
        hold_nxt  = hold;
        burst_nxt = burst;
        count_nxt = trg_count;
        trg_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && mode != 2'd0) begin
                    state_nxt = RUN;
                    mode_nxt  = mode;
                    cnt_nxt   = rate;
                    hold_nxt  = '0;
                    burst_nxt = '0;
                    count_nxt = '0;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    if (mode_q == MODE_PER || mode_q == MODE_BST) begin
                        cnt_nxt = expiry ? rate : cnt - CNT_ONE;
                    end
                    if (mode_q == MODE_BST) begin
                        burst_nxt = (burst_eff != '0) ? burst_eff - HOLD_ONE : '0;
                    end
                    if (issue) begin
                        trg_nxt  = 1'b1;
                        hold_nxt = holdoff;
                        if (trg_count != '1) begin
                            count_nxt = trg_count + 32'd1;
                        end
                        if (count_limit != '0 && count_nxt == count_limit) begin
                            state_nxt = DONE;
                        end
                    end else if (hold != '0) begin
                        hold_nxt = hold - HOLD_ONE;
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= 2'd0;
            cnt       <= '0;
            hold      <= '0;
            burst     <= '0;
            trg_count <= '0;
            trg_q     <= 1'b0;
        end else if (sync) begin
            state     <= state_nxt;
            mode_q    <= mode_nxt;
            cnt       <= cnt_nxt;
            hold      <= hold_nxt;
            burst     <= burst_nxt;
            trg_count <= count_nxt;
            trg_q     <= trg_nxt;
        end
    end

    always_comb begin
        trg          = '0;
        trg[TRG_BIT] = trg_q;
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_trigger_generator_mc.sv
// Scoreboard bench for trigger_generator_mc: expectations are queued per sync tick
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_trigger_generator_mc;

    localparam logic [4:0] T = 5'b00010;
    localparam logic [4:0] Z = 5'b00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sync = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] rate = '0;
    logic [15:0] holdoff = '0;
    logic [15:0] burst_len = '0;
    logic [31:0] count_limit = '0;
    logic [4:0]  trg;
    logic        busy;
    logic        done;
    logic [31:0] trg_count;
`ifdef TRG_EXT_EN
    logic        ext_trg = 1'b0;
`endif

    typedef struct {
        int          tk;
        logic [4:0]  trg;
        logic        busy;
        logic        done;
        logic [31:0] cnt;
        logic        seen;
        string       nm;
    } exp_t;

    exp_t  q[$];
    int    ticks = 0;
    int    base = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    sync_div = 1'b0;
    string tname = "";

    trigger_generator_mc dut (
        .clk         (clk),
        .reset       (reset),
        .sync        (sync),
        .enable      (enable),
        .mode        (mode),
        .rate        (rate),
        .holdoff     (holdoff),
        .burst_len   (burst_len),
        .count_limit (count_limit),
`ifdef TRG_EXT_EN
        .ext_trg     (ext_trg),
`endif
        .trg         (trg),
        .busy        (busy),
        .done        (done),
        .trg_count   (trg_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sync) ticks++;
    end

    always @(posedge clk) begin
        #1;
        sync = sync_div ? ~sync : 1'b1;
    end

    // Monitor: every entry for the current tick is compared on each falling edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tk < ticks) begin
            if (!q[0].seen) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s tick %0d: entry never compared (now %0d)",
                         q[0].nm, q[0].tk, ticks);
            end
            void'(q.pop_front());
        end
        foreach (q[i]) begin
            if (q[i].tk == ticks) begin
                q[i].seen = 1'b1;
                n_cmp++;
                if (trg !== q[i].trg || busy !== q[i].busy ||
                    done !== q[i].done || trg_count !== q[i].cnt) begin
                    n_bad++;
                    $display("FAIL %s tick %0d: got trg=%b busy=%b done=%b cnt=%0d, want trg=%b busy=%b done=%b cnt=%0d",
                             q[i].nm, q[i].tk, trg, busy, done, trg_count,
                             q[i].trg, q[i].busy, q[i].done, q[i].cnt);
                end
            end
        end
    end

    task automatic wait_ticks(int n);
        int t = ticks + n;
        while (ticks < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_tick(int k, logic [4:0] t, logic b, logic d, logic [31:0] c);
        exp_t e;
        e.tk   = base + 1 + k;
        e.trg  = t;
        e.busy = b;
        e.done = d;
        e.cnt  = c;
        e.seen = 1'b0;
        e.nm   = tname;
        q.push_back(e);
    endtask

    task automatic setup(string nm, logic [1:0] m, logic [31:0] r,
                         logic [15:0] h, logic [15:0] bl, logic [31:0] lim);
        tname       = nm;
        mode        = m;
        rate        = r;
        holdoff     = h;
        burst_len   = bl;
        count_limit = lim;
        base        = ticks;
    endtask

    task automatic run(int n_on, int n_off);
        enable = 1'b1;
        wait_ticks(n_on);
        enable = 1'b0;
        wait_ticks(n_off);
    endtask

    // Expectation is checked within the same clk cycle the reset is raised.
    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        tname  = "reset";
        base   = ticks;
        expect_tick(-1, Z, 1'b0, 1'b0, 32'd0);
        wait_ticks(2);
        reset = 1'b0;
    endtask

    task automatic run_random(string nm, logic [31:0] r, int n);
        logic [31:0] sa, sb, sc, s;
        logic        hit;
        int          c = 0;
        do_reset();
        setup(nm, 2'd2, r, 16'd0, 16'd0, 32'd0);
        sa = '1;
        sb = '1;
        sc = '1;
        for (int k = 0; k < n; k++) begin
            s   = sa ^ sb ^ sc;
            hit = (k > 0) && (s < r);
            if (hit) c++;
            expect_tick(k, hit ? T : Z, 1'b1, 1'b0, c);
            sa = {sa[19:1], sa[18:6] ^ sa[31:19]};
            sb = {sb[27:3], sb[29:23] ^ sb[31:25]};
            sc = {sc[14:4], sc[28:8] ^ sc[31:11]};
        end
        expect_tick(n, Z, 1'b0, 1'b0, c);
        run(n, 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget at tick %0d", ticks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait_ticks(1);
        do_reset();

        // Periodic, rate=3: triggers every 4th tick.
        setup("periodic_r3", 2'd1, 32'd3, 16'd0, 16'd0, 32'd0);
        for (int k = 0; k < 14; k++)
            expect_tick(k, (k > 0 && k % 4 == 0) ? T : Z, 1'b1, 1'b0, k / 4);
        expect_tick(14, Z, 1'b0, 1'b0, 32'd3);
        run(14, 2);

        // Periodic, rate=0 with holdoff=2: two of every three candidates dropped.
        setup("holdoff", 2'd1, 32'd0, 16'd2, 16'd0, 32'd0);
        for (int k = 0; k < 12; k++)
            expect_tick(k, (k > 0 && (k - 1) % 3 == 0) ? T : Z, 1'b1, 1'b0, (k + 2) / 3);
        expect_tick(12, Z, 1'b0, 1'b0, 32'd4);
        run(12, 2);

        // Burst: rate=9, 3 per burst, limit 5 -> triggers 10,11,12,20,21 then DONE.
        setup("burst_limit", 2'd3, 32'd9, 16'd0, 16'd3, 32'd5);
        for (int k = 0; k < 30; k++) begin
            int  c;
            bit  hit;
            hit = (k == 10 || k == 11 || k == 12 || k == 20 || k == 21);
            c = (k >= 10) + (k >= 11) + (k >= 12) + (k >= 20) + (k >= 21);
            expect_tick(k, hit ? T : Z, k < 21, k >= 21, c);
        end
        expect_tick(30, Z, 1'b0, 1'b0, 32'd5);
        run(30, 2);

        // Abort before the first expiry.
        setup("abort", 2'd1, 32'd7, 16'd0, 16'd0, 32'd0);
        for (int k = 0; k < 5; k++)
            expect_tick(k, Z, 1'b1, 1'b0, 32'd0);
        for (int k = 5; k < 10; k++)
            expect_tick(k, Z, 1'b0, 1'b0, 32'd0);
        run(5, 5);

        // Asynchronous reset while running with a nonzero count.
        setup("pre_reset", 2'd1, 32'd3, 16'd0, 16'd0, 32'd0);
        for (int k = 0; k < 6; k++)
            expect_tick(k, (k == 4) ? T : Z, 1'b1, 1'b0, (k >= 4) ? 1 : 0);
        enable = 1'b1;
        wait_ticks(7);
        do_reset();

        // Sync asserted every other clk: state only advances on sync ticks.
        sync_div = 1'b1;
        setup("sync_gate", 2'd1, 32'd1, 16'd0, 16'd0, 32'd0);
        for (int k = 0; k < 8; k++)
            expect_tick(k, (k > 0 && k % 2 == 0) ? T : Z, 1'b1, 1'b0, k / 2);
        expect_tick(8, Z, 1'b0, 1'b0, 32'd3);
        run(8, 2);
        sync_div = 1'b0;
        wait_ticks(2);

        run_random("random_half", 32'h8000_0000, 40);
        run_random("random_zero", 32'h0000_0000, 1000);
        run_random("random_max", 32'hFFFF_FFFF, 30);

`ifdef TRG_EXT_EN
        // External edges: one lands in a gap (tick 5), one inside holdoff (tick 17).
        setup("ext_trg", 2'd1, 32'd7, 16'd2, 16'd0, 32'd0);
        for (int k = 0; k < 26; k++) begin
            int c;
            bit hit;
            hit = (k == 5 || k == 8 || k == 16 || k == 24);
            c = (k >= 5) + (k >= 8) + (k >= 16) + (k >= 24);
            expect_tick(k, hit ? T : Z, 1'b1, 1'b0, c);
        end
        expect_tick(26, Z, 1'b0, 1'b0, 32'd4);
        enable = 1'b1;
        wait_ticks(3);
        ext_trg = 1'b1;
        wait_ticks(1);
        ext_trg = 1'b0;
        wait_ticks(11);
        ext_trg = 1'b1;
        wait_ticks(1);
        ext_trg = 1'b0;
        wait_ticks(10);
        enable = 1'b0;
        wait_ticks(2);
`endif

        wait_ticks(2);
        foreach (q[i]) begin
            if (!q[i].seen) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s tick %0d: entry never compared (now %0d)",
                         q[i].nm, q[i].tk, ticks);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
